// File: rtl/alu_mc.sv
// alu_mc: handshaked execute-stage ALU covering all sixteen ARM data-processing
// opcodes, with a registered valid/ready output stage.
// Optional feature macro: ALU_MC_MUL_EN builds the iterative shift-add
// multiplier (MUL/MLA). Without it, mul/acc/ra are ignored and the FSM stays
// in IDLE.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic             mul,
  input  logic             acc,
  input  logic [WIDTH-1:0] rn,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH-1:0] ra,
  input  logic             op2_carry,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  typedef enum logic {IDLE, MUL} state_t;

  state_t state;

  logic             accept;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic             is_arith;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_result;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Operand selection: arithmetic ops map onto one adder with optionally
  // inverted/swapped operands; logical ops produce their result directly.
  always_comb begin
    add_a     = rn;
    add_b     = op2;
    add_cin   = 1'b0;
    is_arith  = 1'b0;
    logic_res = '0;
    case (opcode)
      4'h0: logic_res = rn & op2;
      4'h1: logic_res = rn ^ op2;
      4'h2: begin add_a = rn;  add_b = ~op2; add_cin = 1'b1;        is_arith = 1'b1; end
      4'h3: begin add_a = op2; add_b = ~rn;  add_cin = 1'b1;        is_arith = 1'b1; end
      4'h4: begin add_a = rn;  add_b = op2;  add_cin = 1'b0;        is_arith = 1'b1; end
      4'h5: begin add_a = rn;  add_b = op2;  add_cin = flags_in[1]; is_arith = 1'b1; end
      4'h6: begin add_a = rn;  add_b = ~op2; add_cin = flags_in[1]; is_arith = 1'b1; end
      4'h7: begin add_a = op2; add_b = ~rn;  add_cin = flags_in[1]; is_arith = 1'b1; end
      4'h8: logic_res = rn & op2;
      4'h9: logic_res = rn ^ op2;
      4'hA: begin add_a = rn;  add_b = ~op2; add_cin = 1'b1;        is_arith = 1'b1; end
      4'hB: begin add_a = rn;  add_b = op2;  add_cin = 1'b0;        is_arith = 1'b1; end
      4'hC: logic_res = rn | op2;
      4'hD: logic_res = op2;
      4'hE: logic_res = rn & ~op2;
      default: logic_res = ~op2;
    endcase
  end

  // Extended-width sum; bit WIDTH is the architectural carry (1 = no borrow).
  always_comb begin
    sum_ext    = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    alu_result = is_arith ? sum_ext[WIDTH-1:0] : logic_res;
    alu_c      = is_arith ? sum_ext[WIDTH] : op2_carry;
    alu_v      = is_arith ? ((add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                             (sum_ext[WIDTH-1] != add_a[WIDTH-1]))
                          : flags_in[3];
    alu_flags  = {alu_v, alu_result[WIDTH-1], alu_c, (alu_result == '0)};
  end

`ifdef ALU_MC_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             mul_c;
  logic             mul_v;
  logic [WIDTH-1:0] mul_next;

  // One shift-add step: accumulate the multiplicand when the multiplier LSB is set.
  always_comb begin
    mul_next = acc_reg + (mplier[0] ? mcand : '0);
  end

  assign busy = (state == MUL);
`else
  logic unused_mul_inputs;

  assign unused_mul_inputs = ^{mul, acc, ra};
  assign busy              = 1'b0;
`endif

  // Control FSM and output register: single-cycle ops register on accept,
  // multiplies iterate in MUL and register after WIDTH steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
`ifdef ALU_MC_MUL_EN
      acc_reg   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      mul_c     <= 1'b0;
      mul_v     <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef ALU_MC_MUL_EN
            if (mul) begin
              state   <= MUL;
              acc_reg <= acc ? ra : '0;
              mcand   <= rn;
              mplier  <= op2;
              count   <= '0;
              mul_c   <= flags_in[1];
              mul_v   <= flags_in[3];
            end else begin
              result    <= alu_result;
              flags     <= alu_flags;
              out_valid <= 1'b1;
            end
`else
            result    <= alu_result;
            flags     <= alu_flags;
            out_valid <= 1'b1;
`endif
          end
        end
`ifdef ALU_MC_MUL_EN
        MUL: begin
          acc_reg <= mul_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          count   <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state     <= IDLE;
            result    <= mul_next;
            flags     <= {mul_v, mul_next[WIDTH-1], mul_c, (mul_next == '0)};
            out_valid <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
